// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID->EX pipeline register with valid/ready skid buffer and sync flush.
// Optional stall/flush performance counters under ID_EX_PERF_CNT_EN.
module id_ex_pipe_stage #(
  parameter int XLEN      = 32,
  parameter int NUM_SRC   = 2,
  parameter int REGADDR_W = 5,
  parameter int OPC_W     = 7,
  parameter int CTRL_W    = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SRC*REGADDR_W-1:0] in_rs_addr,
  input  logic [NUM_SRC*XLEN-1:0]      in_rs_data,
  input  logic [XLEN-1:0]              in_imm,
  input  logic [REGADDR_W-1:0]         in_rd,
  input  logic [OPC_W-1:0]             in_opcode,
  input  logic [CTRL_W-1:0]            in_ctrl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_SRC*REGADDR_W-1:0] out_rs_addr,
  output logic [NUM_SRC*XLEN-1:0]      out_rs_data,
  output logic [XLEN-1:0]              out_imm,
  output logic [REGADDR_W-1:0]         out_rd,
  output logic [OPC_W-1:0]             out_opcode,
`ifdef ID_EX_PERF_CNT_EN
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
`else
  output logic [CTRL_W-1:0]            out_ctrl
`endif
);
  localparam int PW = NUM_SRC*REGADDR_W + NUM_SRC*XLEN + XLEN + REGADDR_W + OPC_W + CTRL_W;
  logic [PW-1:0] in_p, main_q, skid_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic main_valid, skid_valid, accept, consume, load_main;
  assign in_p = {in_rs_addr, in_rs_data, in_imm, in_rd, in_opcode, in_ctrl};
  assign {out_rs_addr, out_rs_data, out_imm, out_rd, out_opcode, main_ctrl} = main_q;
  // Bubbles carry an all-zero control word so nothing downstream fires.
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_valid = main_valid;
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign consume   = main_valid & out_ready;
  assign load_main = ~main_valid | consume;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (!flush && load_main && (skid_valid || accept))
        main_q <= skid_valid ? skid_q : in_p;
      if (!flush && !load_main && accept)
        skid_q <= in_p;
      main_valid <= ~flush & (load_main ? (skid_valid | accept) : 1'b1);
      skid_valid <= ~flush & ~load_main & (skid_valid | accept);
    end
  end
`ifdef ID_EX_PERF_CNT_EN
  // A beat consumed in the flush cycle reached EX, so it is not counted as squashed.
  logic [1:0] squashed;
  assign squashed = {1'b0, main_valid & ~out_ready} + {1'b0, skid_valid};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, main_valid & ~out_ready};
      flush_cnt <= flush_cnt + (flush ? {30'd0, squashed} : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb_id_ex_pipe_stage: table-driven check of the ID/EX skid stage plus reset, flush and wide-build sequences.
module tb_id_ex_pipe_stage;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [9:0] in_rs_addr, out_rs_addr;
  logic [63:0] in_rs_data, out_rs_data;
  logic [31:0] in_imm, out_imm;
  logic [4:0] in_rd, out_rd;
  logic [6:0] in_opcode, out_opcode;
  logic [23:0] in_ctrl, out_ctrl;
  logic w_in_valid = 0, w_in_ready, w_out_valid;
  logic [14:0] w_in_rs_addr = '0, w_out_rs_addr;
  logic [191:0] w_in_rs_data = '0, w_out_rs_data;
  logic [63:0] w_in_imm = '0, w_out_imm;
  logic [4:0] w_out_rd;
  logic [6:0] w_out_opcode;
  logic [23:0] w_out_ctrl;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, w_stall_cnt, w_flush_cnt;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  id_ex_pipe_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rs_data(in_rs_data), .in_imm(in_imm), .in_rd(in_rd),
    .in_opcode(in_opcode), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_addr(out_rs_addr), .out_rs_data(out_rs_data), .out_imm(out_imm), .out_rd(out_rd),
    .out_opcode(out_opcode),
`ifdef ID_EX_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .out_ctrl(out_ctrl));
  id_ex_pipe_stage #(.XLEN(64), .NUM_SRC(3)) u_wide (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_rs_addr(w_in_rs_addr), .in_rs_data(w_in_rs_data), .in_imm(w_in_imm), .in_rd(5'd9),
    .in_opcode(7'h33), .in_ctrl(24'h000001), .out_valid(w_out_valid), .out_ready(1'b1),
    .out_rs_addr(w_out_rs_addr), .out_rs_data(w_out_rs_data), .out_imm(w_out_imm), .out_rd(w_out_rd),
    .out_opcode(w_out_opcode),
`ifdef ID_EX_PERF_CNT_EN
    .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt),
`endif
    .out_ctrl(w_out_ctrl));
  typedef struct {
    logic iv; logic [7:0] id; logic ordy; logic fl;
    logic eov; logic eir; logic [7:0] eid;
  } vec_t;
  vec_t v[18];
  function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy, logic fl,
                              logic eov, logic eir, logic [7:0] eid);
    mk.iv = iv; mk.id = id; mk.ordy = ordy; mk.fl = fl;
    mk.eov = eov; mk.eir = eir; mk.eid = eid;
  endfunction
  function automatic logic [141:0] beat(logic [7:0] id, logic valid);
    logic [23:0] c;
    c = valid ? {16'h5A5A, id} : 24'h0;
    return {id[4:0] + 5'd1, id[4:0], 32'hA000_0000 | {24'h0, id}, 32'hB000_0000 | {24'h0, id},
            {24'hC00000, id}, id[4:0], id[6:0], c};
  endfunction
  function automatic logic [141:0] actual();
    return {out_rs_addr, out_rs_data, out_imm, out_rd, out_opcode, out_ctrl};
  endfunction
  task automatic drive(logic iv, logic [7:0] id, logic ordy, logic fl);
    logic [141:0] b;
    b = beat(id, 1'b1);
    in_valid = iv; out_ready = ordy; flush = fl;
    {in_rs_addr, in_rs_data, in_imm, in_rd, in_opcode, in_ctrl} = b;
  endtask
  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  logic prev_ov, prev_ir;
  logic [31:0] exp_stall, exp_flush;
  initial begin
    v[0]  = mk(1,  1, 1, 0, 1, 1,  1);
    v[1]  = mk(1,  2, 1, 0, 1, 1,  2);
    v[2]  = mk(1,  3, 1, 0, 1, 1,  3);
    v[3]  = mk(0,  0, 1, 0, 0, 1,  3);
    v[4]  = mk(1,  4, 0, 0, 1, 1,  4);
    v[5]  = mk(1,  5, 0, 0, 1, 0,  4);
    v[6]  = mk(1,  6, 0, 0, 1, 0,  4);
    v[7]  = mk(1,  7, 1, 0, 1, 1,  5);
    v[8]  = mk(0,  0, 1, 0, 0, 1,  5);
    v[9]  = mk(1,  8, 0, 0, 1, 1,  8);
    v[10] = mk(1,  9, 0, 0, 1, 0,  8);
    v[11] = mk(1, 10, 0, 1, 0, 1,  8);
    v[12] = mk(0,  0, 1, 0, 0, 1,  8);
    v[13] = mk(1, 11, 1, 0, 1, 1, 11);
    v[14] = mk(1, 12, 1, 1, 0, 1, 11);
    v[15] = mk(1, 13, 0, 0, 1, 1, 13);
    v[16] = mk(0,  0, 0, 0, 1, 1, 13);
    v[17] = mk(1, 14, 0, 0, 1, 0, 13);
    drive(1, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {255'd0, out_valid}, 256'd0);
    chk("reset in_ready", {255'd0, in_ready}, 256'd1);
    chk("reset payload", {114'd0, actual()}, 256'd0);
    reset = 1;
    prev_ov = 0; prev_ir = 1; exp_stall = 0; exp_flush = 0;
    for (int i = 0; i < 18; i++) begin
      drive(v[i].iv, v[i].id, v[i].ordy, v[i].fl);
      exp_stall += {31'd0, prev_ov & ~v[i].ordy};
      if (v[i].fl) exp_flush += {31'd0, prev_ov & ~v[i].ordy} + {31'd0, ~prev_ir};
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {255'd0, out_valid}, {255'd0, v[i].eov});
      chk($sformatf("v%0d in_ready", i), {255'd0, in_ready}, {255'd0, v[i].eir});
      chk($sformatf("v%0d payload", i), {114'd0, actual()}, {114'd0, beat(v[i].eid, v[i].eov)});
      prev_ov = v[i].eov; prev_ir = v[i].eir;
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt", {224'd0, stall_cnt}, {224'd0, exp_stall});
    chk("flush_cnt", {224'd0, flush_cnt}, {224'd0, exp_flush});
`endif
    #2 reset = 0;
    #1;
    chk("async reset out_valid", {255'd0, out_valid}, 256'd0);
    chk("async reset in_ready", {255'd0, in_ready}, 256'd1);
    chk("async reset payload", {114'd0, actual()}, 256'd0);
    #2 reset = 1;
    drive(1, 15, 1, 0);
    @(posedge clk);
    #1;
    chk("post reset out_valid", {255'd0, out_valid}, 256'd1);
    chk("post reset in_ready", {255'd0, in_ready}, 256'd1);
    chk("post reset payload", {114'd0, actual()}, {114'd0, beat(15, 1)});
`ifdef ID_EX_PERF_CNT_EN
    chk("post reset stall_cnt", {224'd0, stall_cnt}, 256'd0);
    chk("post reset flush_cnt", {224'd0, flush_cnt}, 256'd0);
`endif
    drive(0, 0, 1, 0);
    w_in_valid = 1;
    w_in_rs_data = {64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    w_in_imm = 64'hFFFF_FFFF_FFFF_FFF0;
    @(posedge clk);
    #1;
    w_in_valid = 0;
    chk("wide out_valid", {255'd0, w_out_valid}, 256'd1);
    chk("wide ch2 data", {192'd0, w_out_rs_data[191:128]}, {192'd0, 64'hDEAD_BEEF_0123_4567});
    chk("wide ch0 data", {192'd0, w_out_rs_data[63:0]}, {192'd0, 64'h5555_6666_7777_8888});
    chk("wide imm", {192'd0, w_out_imm}, {192'd0, 64'hFFFF_FFFF_FFFF_FFF0});
    chk("wide ctrl", {232'd0, w_out_ctrl}, 256'd1);
    chk("drain out_valid", {255'd0, out_valid}, 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
